// File: rtl/axi_burst_master_if.sv
// ============================================================================
// axi_burst_master_if : AXI4 bus bundle (AW/W/B/AR/R) with master/slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_burst_master_if;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;

  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;

  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;

  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi_burst_master.sv
// ============================================================================
// axi_burst_master : single-outstanding AXI4 INCR burst master, 32-bit beats
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_burst_master #(
  parameter logic [3:0] ID = 4'h0
) (
  input  wire logic        ACLK,
  input  wire logic        ARESETn,

  input  wire logic        i_cmd_valid,
  output logic             o_cmd_ready,
  input  wire logic        i_cmd_write,
  input  wire logic [31:0] i_cmd_addr,
  input  wire logic [7:0]  i_cmd_len,

  input  wire logic [31:0] i_wr_data,
  input  wire logic [3:0]  i_wr_strb,
  input  wire logic        i_wr_valid,
  output logic             o_wr_ready,

  output logic [31:0]      o_rd_data,
  output logic             o_rd_last,
  output logic             o_rd_valid,
  input  wire logic        i_rd_ready,

  output logic             o_done,
  output logic             o_err,

  axi_burst_master_if.master m_axi
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5
  } state_t;

  localparam logic [2:0] c_SIZE_4B = 3'b010;
  localparam logic [1:0] c_BURST_INCR = 2'b01;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_cmd_ready;
  logic        r_awvalid;
  logic        r_arvalid;
  logic        r_w_en;
  logic        r_bready;
  logic        r_r_en;
  logic        r_done;
  logic        r_err;

  logic w_last;
  logic w_w_hs;
  logic w_r_hs;
  logic w_r_err;

  // The beat counter alone marks the final beat; it never decrements past 0.
  assign w_last  = (r_cnt == 8'd0);
  assign w_w_hs  = r_w_en & i_wr_valid & m_axi.WREADY;
  assign w_r_hs  = r_r_en & m_axi.RVALID & i_rd_ready;
  assign w_r_err = (m_axi.RRESP != 2'b00) | (m_axi.RID != ID) | (m_axi.RLAST != w_last);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_w_en      <= 1'b0;
      r_bready    <= 1'b0;
      r_r_en      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_addr      <= i_cmd_addr & ~32'h3;
            r_len       <= i_cmd_len;
            r_cnt       <= i_cmd_len;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            if (i_cmd_write) begin
              r_awvalid <= 1'b1;
              r_state   <= S_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AW: begin
          if (m_axi.AWREADY) begin
            r_awvalid <= 1'b0;
            r_w_en    <= 1'b1;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            if (w_last) begin
              r_w_en   <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        S_B: begin
          if (m_axi.BVALID) begin
            r_err       <= (m_axi.BRESP != 2'b00) | (m_axi.BID != ID);
            r_done      <= 1'b1;
            r_bready    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_AR: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_r_en    <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (w_r_hs) begin
            r_err <= r_err | w_r_err;
            if (w_last) begin
              r_r_en      <= 1'b0;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_awvalid   <= 1'b0;
          r_arvalid   <= 1'b0;
          r_w_en      <= 1'b0;
          r_bready    <= 1'b0;
          r_r_en      <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_done      = r_done;
  assign o_err       = r_err;

  assign m_axi.AWID    = ID;
  assign m_axi.AWADDR  = r_addr;
  assign m_axi.AWLEN   = r_len;
  assign m_axi.AWSIZE  = c_SIZE_4B;
  assign m_axi.AWBURST = c_BURST_INCR;
  assign m_axi.AWLOCK  = 1'b0;
  assign m_axi.AWCACHE = 4'h0;
  assign m_axi.AWPROT  = 3'h0;
  assign m_axi.AWVALID = r_awvalid;

  // Write and read data paths are combinational pass-through gated by state.
  assign m_axi.WDATA  = i_wr_data;
  assign m_axi.WSTRB  = i_wr_strb;
  assign m_axi.WLAST  = r_w_en & w_last;
  assign m_axi.WVALID = r_w_en & i_wr_valid;
  assign o_wr_ready   = r_w_en & m_axi.WREADY;

  assign m_axi.BREADY = r_bready;

  assign m_axi.ARID    = ID;
  assign m_axi.ARADDR  = r_addr;
  assign m_axi.ARLEN   = r_len;
  assign m_axi.ARSIZE  = c_SIZE_4B;
  assign m_axi.ARBURST = c_BURST_INCR;
  assign m_axi.ARLOCK  = 1'b0;
  assign m_axi.ARCACHE = 4'h0;
  assign m_axi.ARPROT  = 3'h0;
  assign m_axi.ARVALID = r_arvalid;

  assign o_rd_data    = m_axi.RDATA;
  assign o_rd_last    = r_r_en & w_last;
  assign o_rd_valid   = r_r_en & m_axi.RVALID;
  assign m_axi.RREADY = r_r_en & i_rd_ready;

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_master.sv
// ============================================================================
// tb_axi_burst_master : directed bench with scoreboard for axi_burst_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_burst_master;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        done;
  logic        err;

  axi_burst_master_if bus ();

  axi_burst_master #(.ID(4'h0)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_len   (cmd_len),
    .i_wr_data   (wr_data),
    .i_wr_strb   (wr_strb),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .o_rd_data   (rd_data),
    .o_rd_last   (rd_last),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_done      (done),
    .o_err       (err),
    .m_axi       (bus)
  );

  always #5 ACLK = ~ACLK;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] sb[$];
  logic        pend_done = 1'b0;
  logic        last_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_slave();
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    bus.BVALID = 1'b0; bus.BID = 4'h0; bus.BRESP = 2'b00;
    bus.ARREADY = 1'b0;
    bus.RVALID = 1'b0; bus.RID = 4'h0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0;
  endtask

  // Inputs that would leak through an ungated path are held high here.
  task automatic reset_check(input string tag);
    wr_valid = 1'b1; bus.WREADY = 1'b1; bus.RVALID = 1'b1; rd_ready = 1'b1;
    @(negedge ACLK);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".awvalid"}, bus.AWVALID, 0);
    chk({tag, ".wvalid"}, bus.WVALID, 0);
    chk({tag, ".wlast"}, bus.WLAST, 0);
    chk({tag, ".bready"}, bus.BREADY, 0);
    chk({tag, ".arvalid"}, bus.ARVALID, 0);
    chk({tag, ".rready"}, bus.RREADY, 0);
    chk({tag, ".wr_ready"}, wr_ready, 0);
    chk({tag, ".rd_valid"}, rd_valid, 0);
    chk({tag, ".rd_last"}, rd_last, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".awaddr"}, bus.AWADDR, 0);
    chk({tag, ".awlen"}, bus.AWLEN, 0);
  endtask

  task automatic idle_check();
    cmd_valid = 1'b0;
    @(negedge ACLK);
    chk("idle.done", done, pend_done);
    chk("idle.err", err, last_err);
    chk("idle.cmd_ready", cmd_ready, 1);
    pend_done = 1'b0;
    step();
  endtask

  task automatic issue_cmd(input logic w, input logic [31:0] addr, input logic [7:0] len,
                           input int dly);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_len = len;
    @(negedge ACLK);
    chk("cmd.ready", cmd_ready, 1);
    chk("cmd.done", done, pend_done);
    chk("cmd.err_held", err, last_err);
    pend_done = 1'b0;
    step();
    cmd_valid = 1'b0;
    cmd_addr = $urandom;
    cmd_len = 8'($urandom);
    for (int i = 0; i <= dly; i++) begin
      if (w) bus.AWREADY = (i == dly);
      else   bus.ARREADY = (i == dly);
      @(negedge ACLK);
      chk("cmd.busy", cmd_ready, 0);
      if (w) begin
        chk("aw.valid", bus.AWVALID, 1);
        chk("aw.addr", bus.AWADDR, {addr[31:2], 2'b00});
        chk("aw.len", bus.AWLEN, len);
        chk("aw.size", bus.AWSIZE, 3'b010);
        chk("aw.burst", bus.AWBURST, 2'b01);
        chk("aw.id", bus.AWID, 4'h0);
        chk("aw.no_ar", bus.ARVALID, 0);
      end else begin
        chk("ar.valid", bus.ARVALID, 1);
        chk("ar.addr", bus.ARADDR, {addr[31:2], 2'b00});
        chk("ar.len", bus.ARLEN, len);
        chk("ar.size", bus.ARSIZE, 3'b010);
        chk("ar.burst", bus.ARBURST, 2'b01);
        chk("ar.id", bus.ARID, 4'h0);
        chk("ar.no_aw", bus.AWVALID, 0);
      end
      step();
    end
    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] len, input logic [31:0] base, input logic rnd);
    int beat = 0;
    int guard = 0;
    logic pend = 1'b0;
    logic [31:0] exp;
    while (beat <= int'(len) && guard < 600) begin
      if (!pend) begin
        wr_data = base + 32'(beat);
        wr_strb = wr_data[3:0] ^ 4'hF;
        sb.push_back(wr_data);
        pend = 1'b1;
      end
      wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.WREADY = rnd ? (guard % 2 == 0) : 1'b1;
      @(negedge ACLK);
      chk("w.valid", bus.WVALID, wr_valid);
      chk("w.wr_ready", wr_ready, bus.WREADY);
      if (bus.WVALID && bus.WREADY) begin
        exp = sb.pop_front();
        chk("w.data", bus.WDATA, exp);
        chk("w.strb", bus.WSTRB, exp[3:0] ^ 4'hF);
        chk("w.last", bus.WLAST, (beat == int'(len)));
        beat++;
        pend = 1'b0;
      end else if (bus.WVALID) begin
        chk("w.hold", bus.WDATA, sb[0]);
      end
      step();
      guard++;
    end
    wr_valid = 1'b0;
    bus.WREADY = 1'b0;
    chk("w.beats", beat, int'(len) + 1);
    sb.delete();
  endtask

  task automatic write_resp(input logic [1:0] bresp, input logic [3:0] bid);
    bus.BVALID = 1'b1; bus.BRESP = bresp; bus.BID = bid;
    @(negedge ACLK);
    chk("b.ready", bus.BREADY, 1);
    chk("b.no_done", done, 0);
    step();
    bus.BVALID = 1'b0; bus.BRESP = 2'b00; bus.BID = 4'h0;
    pend_done = 1'b1;
    last_err = (bresp != 2'b00) || (bid != 4'h0);
  endtask

  task automatic read_data(input logic [7:0] len, input logic [31:0] base, input int bad_last,
                           input logic rnd);
    int beat = 0;
    int guard = 0;
    logic pend = 1'b0;
    logic [31:0] exp;
    while (beat <= int'(len) && guard < 600) begin
      if (!pend) begin
        bus.RDATA = base + 32'(beat);
        sb.push_back(bus.RDATA);
        pend = 1'b1;
      end
      bus.RLAST = (bad_last >= 0) ? (beat == bad_last) : (beat == int'(len));
      bus.RVALID = 1'b1;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge ACLK);
      chk("r.valid", rd_valid, bus.RVALID);
      chk("r.rready", bus.RREADY, rd_ready);
      if (rd_valid && rd_ready) begin
        exp = sb.pop_front();
        chk("r.data", rd_data, exp);
        chk("r.last", rd_last, (beat == int'(len)));
        beat++;
        pend = 1'b0;
      end
      step();
      guard++;
    end
    bus.RVALID = 1'b0; bus.RLAST = 1'b0;
    rd_ready = 1'b0;
    chk("r.beats", beat, int'(len) + 1);
    sb.delete();
    pend_done = 1'b1;
    last_err = (bad_last >= 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_slave();
    step();
    reset_check("reset");
    step();
    ARESETn = 1'b1;
    wr_valid = 1'b0; rd_ready = 1'b0;
    clear_slave();
    idle_check();

    // Basic write, then an unaligned single-beat read.
    issue_cmd(1'b1, 32'h10, 8'd3, 0);
    write_data(8'd3, 32'hA0, 1'b0);
    write_resp(2'b00, 4'h0);
    idle_check();
    idle_check();

    issue_cmd(1'b0, 32'h23, 8'd0, 1);
    read_data(8'd0, 32'hDEADBEEF, -1, 1'b0);
    idle_check();

    // Backpressured write with a SLVERR response.
    issue_cmd(1'b1, 32'h100, 8'd7, 2);
    write_data(8'd7, 32'h5000, 1'b1);
    write_resp(2'b10, 4'h0);
    idle_check();
    idle_check();

    // Early RLAST flags an error; counter still runs to the 4th beat.
    issue_cmd(1'b0, 32'h200, 8'd3, 0);
    read_data(8'd3, 32'h7000, 1, 1'b1);
    idle_check();

    // Wrong BID, then a 256-beat read accepted in the done cycle.
    issue_cmd(1'b1, 32'h300, 8'd0, 0);
    write_data(8'd0, 32'h9000, 1'b0);
    write_resp(2'b00, 4'h3);
    issue_cmd(1'b0, 32'h1000, 8'd255, 0);
    read_data(8'd255, 32'h10000000, -1, 1'b0);
    idle_check();
    idle_check();

    // Reset asserted during the second of four write beats.
    issue_cmd(1'b1, 32'h40, 8'd3, 0);
    wr_valid = 1'b1; bus.WREADY = 1'b1; wr_data = 32'hB0; wr_strb = 4'hF;
    @(negedge ACLK);
    chk("rst.beat1", bus.WVALID & bus.WREADY, 1);
    step();
    wr_data = 32'hB1;
    #2;
    ARESETn = 1'b0;
    reset_check("midrst");
    step();
    ARESETn = 1'b1;
    wr_valid = 1'b0; rd_ready = 1'b0;
    clear_slave();
    pend_done = 1'b0;
    last_err = 1'b0;
    idle_check();

    issue_cmd(1'b1, 32'h80, 8'd1, 0);
    write_data(8'd1, 32'hC0, 1'b0);
    write_resp(2'b00, 4'h0);
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
